// File: rtl/gaussian_pkg.sv
// Shared types and constants for the gaussian AFU.
// Holds the read-scheduler state encoding and its default credit depth.
package gaussian_pkg;

  localparam int RD_SCHED_MAX_OUTSTANDING = 64;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2,
    RD_DONE  = 2'd3
  } t_rd_sched_state;

endpackage

// File: rtl/gaussian_credit_counter.sv
// Saturating up/down credit counter with limit compare and underflow detect.
// Count updates one cycle after inc/dec; a dec at zero is flagged and dropped.
module gaussian_credit_counter #(
  parameter int MAX   = 64,
  parameter int CNT_W = $clog2(MAX) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             belowLimit,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX);

  logic decEff;

  assign underflow  = dec && (count == '0);
  assign decEff     = dec && !underflow;
  assign belowLimit = (count < LIMIT);

  // Coincident inc and accepted dec cancel; an underflowing dec never cancels an inc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({inc, decEff})
        2'b10:   if (count != LIMIT) count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gaussian_rd_scheduler.sv
// Walks a contiguous line buffer issuing one c0 read per line, gated by almfull and read credits.
// First request two cycles after start; done pulses two cycles after the final response.
module gaussian_rd_scheduler
  import gaussian_pkg::*;
#(
  parameter int ADDR_W          = 42,
  parameter int LEN_W           = 32,
  parameter int MAX_OUTSTANDING = RD_SCHED_MAX_OUTSTANDING,
  parameter int MDATA_W         = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                base_addr,
  input  logic [LEN_W-1:0]                 num_lines,
  input  logic                             c0_almfull,
  output logic                             rd_req_valid,
  output logic [ADDR_W-1:0]                rd_req_addr,
  output logic [MDATA_W-1:0]               rd_req_mdata,
  input  logic                             rd_rsp_valid,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err_unexpected_rsp
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  t_rd_sched_state state, stateNext;

  logic [ADDR_W-1:0] baseAddr;
  logic [LEN_W-1:0]  numLines;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  received;
  logic [LEN_W-1:0]  receivedNext;
  logic              startAccept;
  logic              issueFire;
  logic              lastIssue;
  logic              rspCounted;
  logic              belowLimit;
  logic              underflow;

  gaussian_credit_counter #(
    .MAX   (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) outstandingCtr (
    .clk        (clk),
    .reset      (reset),
    .inc        (issueFire),
    .dec        (rd_rsp_valid),
    .count      (outstanding),
    .belowLimit (belowLimit),
    .underflow  (underflow)
  );

  assign busy         = (state != RD_IDLE);
  assign startAccept  = (state == RD_IDLE) && start;
  assign issueFire    = (state == RD_ISSUE) && !c0_almfull && belowLimit && (issued < numLines);
  assign lastIssue    = issueFire && ((issued + LEN_W'(1)) == numLines);
  assign rspCounted   = rd_rsp_valid && !underflow;
  assign receivedNext = received + LEN_W'(rspCounted);

  // DRAIN looks at the count including this cycle's response so done lands two cycles later.
  always_comb begin
    stateNext = state;
    case (state)
      RD_IDLE:  if (start) stateNext = (num_lines == '0) ? RD_DONE : RD_ISSUE;
      RD_ISSUE: if (lastIssue) stateNext = RD_DRAIN;
      RD_DRAIN: if (receivedNext == numLines) stateNext = RD_DONE;
      RD_DONE:  if (done) stateNext = RD_IDLE;
      default:  stateNext = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= RD_IDLE;
      baseAddr           <= '0;
      numLines           <= '0;
      issued             <= '0;
      received           <= '0;
      done               <= 1'b0;
      err_unexpected_rsp <= 1'b0;
      rd_req_valid       <= 1'b0;
      rd_req_addr        <= '0;
      rd_req_mdata       <= '0;
    end else begin
      state        <= stateNext;
      // DONE holds two cycles: the first arms the pulse, the second presents it.
      done         <= (state == RD_DONE) && !done;
      rd_req_valid <= issueFire;

      if (issueFire) begin
        rd_req_addr  <= baseAddr + ADDR_W'(issued);
        rd_req_mdata <= issued[MDATA_W-1:0];
        issued       <= issued + LEN_W'(1);
      end

      if (startAccept) begin
        baseAddr           <= base_addr;
        numLines           <= num_lines;
        issued             <= '0;
        received           <= '0;
        err_unexpected_rsp <= 1'b0;
      end else if (rspCounted) begin
        received <= receivedNext;
      end

      if (underflow) err_unexpected_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gaussian_rd_scheduler.sv
// Randomized scoreboard bench for gaussian_rd_scheduler with a transaction-level reference model.
module tb_gaussian_rd_scheduler;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [41:0] base_addr = '0;
  logic [31:0] num_lines = '0;
  logic        c0_almfull = 1'b0;
  logic        rd_rsp_valid = 1'b0;
  logic        rd_req_valid;
  logic [41:0] rd_req_addr;
  logic [15:0] rd_req_mdata;
  logic        busy;
  logic        done;
  logic [2:0]  outstanding;
  logic        err_unexpected_rsp;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int almMode = 0;
  int holdRsp = 0;
  int extraRsp = 0;
  int latMin = 2;
  int latMax = 2;

  logic [41:0] expAddr[$];
  logic [15:0] expMdata[$];
  int          rspDue[$];
  int          doneQ[$];
  int          reqCycs[$];

  int inflight = 0;
  bit errModel = 1'b0;
  int startCyc = -1;
  int curLines = 0;
  int rspCnt = 0;
  int doneCount = 0;
  int reqCount = 0;
  int busyChkCyc = -1;
  bit prevAlm = 1'b0;

  gaussian_rd_scheduler #(
    .ADDR_W          (42),
    .LEN_W           (32),
    .MAX_OUTSTANDING (MAXO),
    .MDATA_W         (16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .base_addr          (base_addr),
    .num_lines          (num_lines),
    .c0_almfull         (c0_almfull),
    .rd_req_valid       (rd_req_valid),
    .rd_req_addr        (rd_req_addr),
    .rd_req_mdata       (rd_req_mdata),
    .rd_rsp_valid       (rd_rsp_valid),
    .busy               (busy),
    .done               (done),
    .outstanding        (outstanding),
    .err_unexpected_rsp (err_unexpected_rsp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [41:0] randBase();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[41:0];
  endfunction

  // Environment: almfull pattern, response generator, then monitor/scoreboard on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (almMode)
        1:       c0_almfull = ((cyc % 4) != 0);
        2:       c0_almfull = ($urandom_range(0, 3) == 0);
        default: c0_almfull = 1'b0;
      endcase
      rd_rsp_valid = 1'b0;
      if (extraRsp > 0) begin
        rd_rsp_valid = 1'b1;
        extraRsp--;
      end else if (holdRsp == 0 && reset && rspDue.size() > 0 && rspDue[0] <= cyc) begin
        rd_rsp_valid = 1'b1;
        void'(rspDue.pop_front());
      end

      @(negedge clk);
      if (!reset) begin
        check("rst_req_valid", rd_req_valid, 0);
        check("rst_req_addr", rd_req_addr, 0);
        check("rst_req_mdata", rd_req_mdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_unexpected_rsp, 0);
        inflight = 0;
        errModel = 1'b0;
      end else begin
        if (rd_req_valid) begin
          reqCount++;
          reqCycs.push_back(cyc);
          if (expAddr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected actual=%0h required=no request", rd_req_addr);
          end else begin
            check("req_addr", rd_req_addr, expAddr.pop_front());
            check("req_mdata", rd_req_mdata, expMdata.pop_front());
          end
          check("almfull_block", prevAlm, 0);
          inflight++;
          rspDue.push_back(cyc + $urandom_range(latMin, latMax));
        end
        check("outstanding", outstanding, inflight);
        check("credit_limit", outstanding <= MAXO, 1);
        check("err_flag", err_unexpected_rsp, errModel);
        if (done) begin
          doneCount++;
          if (doneQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            check("done_cycle", cyc, doneQ.pop_front());
          end
          busyChkCyc = cyc + 1;
        end
        if (cyc == busyChkCyc) check("busy_after_done", busy, 0);
        if (cyc == startCyc) errModel = 1'b0;
        if (rd_rsp_valid) begin
          if (inflight > 0) begin
            inflight--;
            rspCnt++;
            if (rspCnt == curLines) doneQ.push_back(cyc + 2);
          end else begin
            errModel = 1'b1;
          end
        end
      end
      prevAlm = c0_almfull;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doStart(input logic [41:0] base, input int n);
    start     = 1'b1;
    base_addr = base;
    num_lines = n;
    startCyc  = cyc;
    curLines  = n;
    rspCnt    = 0;
    for (int i = 0; i < n; i++) begin
      expAddr.push_back(base + 42'(i));
      expMdata.push_back(16'(i));
    end
    if (n == 0) doneQ.push_back(cyc + 2);
    tick(1);
    start = 1'b0;
    check("start_busy", busy, 1);
  endtask

  task automatic waitDone(input string name, input int budget);
    int target;
    int k;
    target = doneCount + 1;
    k = 0;
    while (doneCount < target && k < budget) begin
      tick(1);
      k++;
    end
    check({name, "_done_seen"}, doneCount >= target, 1);
    check({name, "_reqs_left"}, expAddr.size(), 0);
    tick(2);
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int n0;
    int k;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);

    // Basic back-to-back transfer
    latMin = 2; latMax = 2;
    reqCycs.delete();
    doStart(42'h1000, 8);
    waitDone("basic", 200);
    check("basic_req_count", reqCycs.size(), 8);
    if (reqCycs.size() == 8) begin
      check("basic_first_req", reqCycs[0], startCyc + 2);
      check("basic_burst", reqCycs[7] - reqCycs[0], 7);
    end

    // Credit limit with responses held off
    holdRsp = 1; latMin = 1; latMax = 1;
    n0 = reqCount;
    doStart(randBase(), 10);
    tick(20);
    check("credit_stall_reqs", reqCount - n0, MAXO);
    holdRsp = 0;
    waitDone("credit", 300);
    check("credit_total", reqCount - n0, 10);

    // Periodic almfull backpressure
    almMode = 1; latMin = 1; latMax = 6;
    n0 = reqCount;
    doStart(randBase(), 16);
    waitDone("almfull", 500);
    check("almfull_total", reqCount - n0, 16);
    almMode = 0;

    // Address wrap at the top of the line space
    latMin = 1; latMax = 4;
    doStart(42'h3FFFFFFFFFE, 4);
    waitDone("wrap", 200);

    // Zero-length transfer
    n0 = reqCount;
    doStart(randBase(), 0);
    waitDone("zero", 20);
    check("zero_no_reqs", reqCount - n0, 0);

    // Response while idle
    extraRsp = 1;
    tick(3);
    check("idle_rsp_err", err_unexpected_rsp, 1);
    check("idle_rsp_outstanding", outstanding, 0);

    // Start while busy must be ignored
    latMin = 3; latMax = 3;
    n0 = reqCount;
    doStart(randBase(), 6);
    tick(1);
    start = 1'b1;
    base_addr = randBase();
    num_lines = 50;
    tick(1);
    start = 1'b0;
    waitDone("busy_start", 300);
    check("busy_start_total", reqCount - n0, 6);

    // Randomized transfers
    for (int it = 0; it < 6; it++) begin
      almMode = 2; latMin = 1; latMax = 8;
      doStart(randBase(), $urandom_range(1, 20));
      waitDone("random", 1000);
    end
    almMode = 0;

    // Reset mid-transfer
    holdRsp = 1; latMin = 1; latMax = 1;
    n0 = reqCount;
    doStart(randBase(), 8);
    k = 0;
    while (reqCount - n0 < 3 && k < 50) begin
      tick(1);
      k++;
    end
    check("rst_three_reqs", reqCount - n0 >= 3, 1);
    reset = 1'b0;
    expAddr.delete();
    expMdata.delete();
    doneQ.delete();
    rspCnt = 0;
    curLines = 0;
    startCyc = -1;
    tick(2);
    reset = 1'b1;
    holdRsp = 0;
    k = 0;
    while (rspDue.size() > 0 && k < 50) begin
      tick(1);
      k++;
    end
    tick(3);
    check("rst_stale_err", err_unexpected_rsp, 1);
    check("rst_stale_outstanding", outstanding, 0);
    latMin = 2; latMax = 2;
    n0 = reqCount;
    doStart(randBase(), 2);
    waitDone("post_rst", 100);
    check("post_rst_total", reqCount - n0, 2);
    check("post_rst_err", err_unexpected_rsp, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
